sd_dac_mod: RTL and testbench
=============================

// Module: sd_dac_mod
// PURPOSE
//   First-order sigma-delta DAC modulator sitting downstream of the 8-bit SD
//   control port. It accepts samples from the port through a 1-deep holding
//   register with a valid/ready handshake. It applies one new sample per
//   oversampling period and emits a 1-bit pulse-density stream for an
//   external RC filter/pin.
// PARAMETERS
//   WIDTH     8  sample width, offset-binary (0 = min, 2^(WIDTH-1) = mid, 2^WIDTH-1 = max)
//   OSR_LOG2  5  log2 of clocks per sample period (default 32 clk/sample)
// PORTS
//   clk          in   1      system clock, all state on rising edge
//   reset        in   1      asynchronous, active-low reset
//   enable       in   1      run modulator; 0 = freeze
//   din          in   WIDTH  sample from upstream port
//   din_valid    in   1      sample offered this cycle
//   din_ready    out  1      holding register empty, sample accepted if valid
//   sample_tick  out  1      1-cycle pulse at end of each sample period
//   underrun     out  1      sticky: period ended with holding register empty
//   underrun_clr in   1      clears underrun (set wins if same cycle)
//   sd_out       out  1      pulse-density output
// BEHAVIOUR
//   Reset (reset=0, async): hold_full=0, hold=0, active=2^(WIDTH-1), acc=0,
//     cnt=0, sd_out=0, sample_tick=0, underrun=0; din_ready=1 after release.
//   Handshake: din_ready = ~hold_full (no look-ahead). valid&ready -> hold<=din,
//     hold_full<=1 next edge. valid while !ready is ignored and not stored.
//   Period counter: cnt (OSR_LOG2 bits) increments each enable=1 clock and wraps.
//     sample_tick=1 in the cycle cnt==2^OSR_LOG2-1 and enable=1.
//   Load: on a tick cycle, if hold_full then active<=hold, hold_full<=0.
//     Otherwise active is kept and underrun<=1.
//     The sample is used by the modulator from the next cycle.
//     Tick and accept cannot coincide on one register: ready=0 while full.
//   Modulator, signed acc WIDTH+2 bits, each enable=1 clock:
//     x = active - 2^(WIDTH-1), signed range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//     fb = sd_out ? +2^(WIDTH-1) : -2^(WIDTH-1).
//     acc_n = acc + x - fb; acc <= acc_n; sd_out <= (acc_n >= 0).
//     |acc| <= 2^WIDTH, so no saturation logic is needed.
//     Ones density = active / 2^WIDTH.
//   enable=0: cnt, acc, active frozen; sd_out forced 0 combinationally after
//     the register; sample_tick=0.
//     The handshake and holding register stay live, so a sample can still be
//     accepted. The modulator resumes from the frozen state when enable returns.
//   Reset mid-period or mid-handshake: all state returns to reset values
//     immediately; a pending held sample is lost.
//   Latency: the sample accepted at edge N is used at the first tick after N.
//     It affects sd_out from the edge after that tick.
// TESTING
//   1 Reset: reset=0 with random inputs -> sd_out=0, tick=0, underrun=0, din_ready=1
//     on release; 256 clocks idle -> 128 ones (active=0x80) +/-1.
//   2 Handshake: valid with din=0xC0 -> ready drops next cycle, rises the
//     cycle after the next tick. Second valid (0x11) while full is ignored,
//     and the applied sample is 0xC0.
//   3 Density: din=0x00 -> 0 ones / 256 clk; 0xC0 -> 192+/-1; 0xFF -> 255+/-1;
//     0x80 -> strict 1,0 alternation after settling.
//   4 Underrun: load one sample, send none -> underrun=1 at 2nd tick, active
//     unchanged. underrun_clr -> 0. underrun_clr coincident with a tick -> stays 1.
//   5 Enable gating: enable=0 for 10 clocks mid-period -> sd_out=0, no tick,
//     cnt/acc held. A sample offered during the gap is accepted and
//     applied at the first tick after resume.
//   6 Reset mid-operation: assert reset with hold_full=1 and cnt=17 -> all
//     reset values; after release the held sample is not applied, active=0x80.

Source files
------------

// File: rtl/sd_dac_if.sv
// Sample handshake between the SD control port (master) and the modulator (slave).
interface sd_dac_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/sd_dac_mod.sv
// First-order sigma-delta DAC modulator: 1-deep sample holding register,
// one sample applied per 2^OSR_LOG2-clock period, 1-bit pulse-density output.
module sd_dac_mod #(
    parameter int WIDTH    = 8,
    parameter int OSR_LOG2 = 5
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     enable,
    sd_dac_if.slave  port,
    output logic     sample_tick,
    output logic     underrun,
    input  logic     underrun_clr,
    output logic     sd_out
);
    localparam int AW = WIDTH + 2;
    localparam logic [WIDTH-1:0]     MID  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [AW-1:0] HALF = AW'(2 ** (WIDTH - 1));

    logic [OSR_LOG2-1:0]   cnt;
    logic                  hold_full;
    logic [WIDTH-1:0]      hold;
    logic [WIDTH-1:0]      active;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  acc_n;
    logic signed [AW-1:0]  x;
    logic signed [AW-1:0]  fb;
    logic                  sd_q;
    logic                  accept;

    assign port.din_ready = ~hold_full;
    assign accept         = port.din_valid & ~hold_full;
    assign sample_tick    = enable & (cnt == '1);
    // Gating after the register keeps the feedback state intact while frozen.
    assign sd_out         = sd_q & enable;

    // NOTE: every signal in this block is assigned on every pass, so no latch is inferred.
    always_comb begin
        x     = signed'({2'b00, active}) - HALF;
        fb    = sd_q ? HALF : -HALF;
        acc_n = acc + x - fb;
    end

    // NOTE: non-blocking assignments so each register sees only pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            hold_full <= 1'b0;
            hold      <= '0;
            active    <= MID;
            acc       <= '0;
            sd_q      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (enable) begin
                cnt  <= cnt + 1'b1;
                acc  <= acc_n;
                sd_q <= ~acc_n[AW-1];
            end

            if (sample_tick && hold_full) begin
                active    <= hold;
                hold_full <= 1'b0;
            end

            // A new underrun takes priority over a simultaneous clear.
            if (sample_tick && !hold_full) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end

            // Cannot coincide with the load above: accept requires an empty register.
            if (accept) begin
                hold      <= port.din;
                hold_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sd_dac_mod.sv
// Self-checking bench for sd_dac_mod: per-cycle comparison against a density-error
// model plus directed handshake, density, underrun, gating and reset scenarios.
module tb_sd_dac_mod;
    localparam int WIDTH    = 8;
    localparam int OSR_LOG2 = 5;
    localparam int PERIOD   = 32;

    logic clk          = 1'b0;
    logic reset        = 1'b1;
    logic enable       = 1'b0;
    logic underrun_clr = 1'b0;
    logic sample_tick;
    logic underrun;
    logic sd_out;

    sd_dac_if #(.WIDTH(WIDTH)) bus ();

    sd_dac_mod #(.WIDTH(WIDTH), .OSR_LOG2(OSR_LOG2)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .port        (bus.slave),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .underrun_clr(underrun_clr),
        .sd_out      (sd_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Model: err tracks sum(active) - 256*sum(ones emitted); a one is emitted
    // whenever the running error is non-negative, giving density active/256.
    int m_cnt    = 0;
    int m_err    = 0;
    int m_active = 128;
    int m_hold   = 0;
    bit m_full   = 1'b0;
    bit m_sd     = 1'b0;
    bit m_under  = 1'b0;
    bit m_tick;
    bit m_take;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt = 0; m_err = 0; m_active = 128; m_hold = 0;
            m_full = 1'b0; m_sd = 1'b0; m_under = 1'b0;
        end else begin
            m_tick = enable && (m_cnt == PERIOD - 1);
            m_take = bus.din_valid && !m_full;
            if (enable) begin
                m_err = m_err + m_active - 256 * int'(m_sd);
                m_sd  = (m_err >= 0);
                m_cnt = (m_cnt + 1) % PERIOD;
            end
            if (m_tick && !m_full) m_under = 1'b1;
            else if (underrun_clr) m_under = 1'b0;
            if (m_tick && m_full) begin
                m_active = m_hold;
                m_full   = 1'b0;
            end
            if (m_take) begin
                m_hold = int'(bus.din);
                m_full = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        check("cmp_din_ready",   int'(bus.din_ready), int'(!m_full));
        check("cmp_sample_tick", int'(sample_tick),   int'(enable && (m_cnt == PERIOD - 1)));
        check("cmp_underrun",    int'(underrun),      int'(m_under));
        check("cmp_sd_out",      int'(sd_out),        int'(m_sd && enable));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] v);
        bus.din       = v;
        bus.din_valid = 1'b1;
        cyc(1);
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (!sample_tick && n < 200) begin
            cyc(1);
            n++;
        end
        if (!sample_tick) check("tick_timeout", 0, 1);
    endtask

    task automatic count_ones(input int n, output int k);
        k = 0;
        repeat (n) begin
            cyc(1);
            k += int'(sd_out);
        end
    endtask

    task automatic do_reset();
        bus.din_valid = 1'b0;
        underrun_clr  = 1'b0;
        enable        = 1'b0;
        reset         = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic density(input logic [WIDTH-1:0] v, input int lo, input int hi, input string name);
        int n;
        int k;
        do_reset();
        enable = 1'b1;
        send(v);
        wait_tick(n);
        cyc(1);
        count_ones(256, k);
        check_range(name, k, lo, hi);
    endtask

    initial begin
        int n;
        int k;
        int flips;
        logic prev;

        bus.din       = '0;
        bus.din_valid = 1'b0;
        #1 reset = 1'b0;

        // Reset with random inputs, then idle run at mid-scale.
        repeat (5) begin
            @(negedge clk);
            bus.din       = WIDTH'($urandom);
            bus.din_valid = 1'($urandom);
            enable        = 1'($urandom);
            underrun_clr  = 1'($urandom);
        end
        @(negedge clk);
        bus.din_valid = 1'b0;
        enable        = 1'b0;
        underrun_clr  = 1'b0;
        reset         = 1'b1;
        cyc(1);
        check("rst_ready",    int'(bus.din_ready), 1);
        check("rst_underrun", int'(underrun),      0);
        check("rst_sd_out",   int'(sd_out),        0);
        check("rst_tick",     int'(sample_tick),   0);
        enable = 1'b1;
        count_ones(256, k);
        check_range("idle_density_80", k, 127, 129);

        // Handshake: hold while full, second offer dropped, release after tick.
        wait_tick(n);
        cyc(1);
        send(8'hC0);
        check("ready_drop", int'(bus.din_ready), 0);
        bus.din       = 8'h11;
        bus.din_valid = 1'b1;
        cyc(1);
        bus.din_valid = 1'b0;
        check("full_ignores", int'(bus.din_ready), 0);
        wait_tick(n);
        check("ready_at_tick", int'(bus.din_ready), 0);
        cyc(1);
        check("ready_after_tick", int'(bus.din_ready), 1);
        count_ones(256, k);
        check_range("applied_c0", k, 191, 193);

        // Densities from a fresh reset.
        density(8'h00, 0,   0,   "density_00");
        density(8'hFF, 254, 256, "density_ff");
        density(8'hC0, 191, 193, "density_c0");
        do_reset();
        enable = 1'b1;
        cyc(8);
        prev  = sd_out;
        flips = 0;
        repeat (64) begin
            cyc(1);
            if (sd_out != prev) flips++;
            prev = sd_out;
        end
        check("alternation_80", flips, 64);

        // Underrun behaviour.
        do_reset();
        enable = 1'b1;
        send(8'h40);
        wait_tick(n);
        cyc(1);
        check("no_underrun_first", int'(underrun), 0);
        wait_tick(n);
        cyc(1);
        check("underrun_2nd_tick", int'(underrun), 1);
        count_ones(256, k);
        check_range("active_kept_40", k, 63, 65);
        underrun_clr = 1'b1;
        cyc(1);
        underrun_clr = 1'b0;
        check("underrun_cleared", int'(underrun), 0);
        wait_tick(n);
        check("period_len", n, 30);
        underrun_clr = 1'b1;
        cyc(1);
        underrun_clr = 1'b0;
        check("clr_vs_tick", int'(underrun), 1);

        // Enable gating mid-period with a sample offered in the gap.
        cyc(9);
        enable = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.din       = 8'h20;
                bus.din_valid = 1'b1;
            end
            cyc(1);
            bus.din_valid = 1'b0;
            k += int'(sd_out) + int'(sample_tick);
        end
        check("gap_quiet", k, 0);
        check("gap_accept", int'(bus.din_ready), 0);
        enable = 1'b1;
        wait_tick(n);
        check("resume_period", n, 22);
        cyc(1);
        count_ones(256, k);
        check_range("gap_sample_20", k, 31, 33);

        // Reset with a pending sample and cnt=17.
        do_reset();
        enable = 1'b1;
        wait_tick(n);
        cyc(1);
        send(8'hF0);
        cyc(16);
        #2 reset = 1'b0;
        #1;
        check("midrst_ready",    int'(bus.din_ready), 1);
        check("midrst_underrun", int'(underrun),      0);
        check("midrst_sd_out",   int'(sd_out),        0);
        check("midrst_tick",     int'(sample_tick),   0);
        @(negedge clk);
        reset = 1'b1;
        wait_tick(n);
        check("midrst_period", n, 31);
        cyc(1);
        check("held_sample_lost", int'(underrun), 1);
        count_ones(256, k);
        check_range("midrst_active_80", k, 127, 129);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
